// File: rtl/key_event_arbiter.sv
// Round-robin key event arbiter: pending key pulses are serialised into a FWFT FIFO of key indices.
// Define KEY_ARB_DROP_CNT_EN to build the saturating dropped-event counter; otherwise drop_cnt reads 8'h00.
module key_event_arbiter #(
   parameter int N     = 2,
   parameter int IDW   = 1,
   parameter int DEPTH = 4,
   parameter int PW    = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   key_pulse,
   output logic           evt_valid,
   output logic [IDW-1:0] evt_id,
   input  logic           evt_ready,
   output logic [N-1:0]   pend,
   output logic           ovf,
   input  logic           ovf_clr,
   output logic [7:0]     drop_cnt
);

   localparam logic [PW:0]    DEPTH_C  = (PW+1)'(DEPTH);
   localparam logic [IDW-1:0] LAST_KEY = IDW'(N-1);

   logic [N-1:0]   pend_r;
   logic [N-1:0]   grant_s;
   logic [N-1:0]   drop_s;
   logic [IDW-1:0] rr_ptr_r;
   logic [IDW-1:0] grant_idx_s;
   logic           grant_vld_s;
   logic           pop_s;
   logic           push_ok_s;
   logic [PW-1:0]  rd_ptr_r;
   logic [PW-1:0]  wr_ptr_r;
   logic [PW:0]    count_r;
   logic [IDW-1:0] mem_r [DEPTH];
   logic           ovf_r;

   function automatic int bit_count(input logic [N-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < N; i++) begin
         c = c + int'(v[i]);
      end
      return c;
   endfunction

   assign pop_s     = (count_r != {(PW+1){1'b0}}) & evt_ready;
   assign push_ok_s = (count_r < DEPTH_C) | pop_s;
   assign drop_s    = key_pulse & pend_r & ~grant_s;

   // Round-robin pick: first pending key above the last granted one, wrapping.
   always_comb begin
      int idx;
      idx         = 0;
      grant_s     = {N{1'b0}};
      grant_idx_s = rr_ptr_r;
      grant_vld_s = 1'b0;
      if (push_ok_s) begin
         for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr_r) + k) % N;
            if (!grant_vld_s && pend_r[idx]) begin
               grant_vld_s = 1'b1;
               grant_idx_s = IDW'(idx);
            end else begin
               grant_vld_s = grant_vld_s;
            end
         end
      end else begin
         grant_vld_s = 1'b0;
      end
      if (grant_vld_s) begin
         grant_s[grant_idx_s] = 1'b1;
      end else begin
         grant_s = {N{1'b0}};
      end
   end

   // Pending vector, round-robin pointer and sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_r   <= {N{1'b0}};
         rr_ptr_r <= LAST_KEY;
         ovf_r    <= 1'b0;
      end else begin
         pend_r <= (pend_r & ~grant_s) | key_pulse;
         if (grant_vld_s) begin
            rr_ptr_r <= grant_idx_s;
         end
         if (|drop_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Event FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {IDW{1'b0}};
         end
      end else begin
         if (grant_vld_s) begin
            mem_r[wr_ptr_r] <= grant_idx_s;
            wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         end
         case ({grant_vld_s, pop_s})
            2'b10:   count_r <= count_r + (PW+1)'(1'b1);
            2'b01:   count_r <= count_r - (PW+1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

`ifdef KEY_ARB_DROP_CNT_EN
   logic [7:0] drop_cnt_r;
   logic [7:0] drop_cnt_nxt_s;

   // Saturating sum of events lost this cycle.
   always_comb begin
      int tot;
      tot = int'(drop_cnt_r) + bit_count(drop_s);
      if (tot > 255) begin
         drop_cnt_nxt_s = 8'hFF;
      end else begin
         drop_cnt_nxt_s = 8'(tot);
      end
   end

   // Drop counter survives ovf_clr; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_r <= 8'h00;
      end else begin
         drop_cnt_r <= drop_cnt_nxt_s;
      end
   end

   assign drop_cnt = drop_cnt_r;
`else
   assign drop_cnt = 8'h00;
`endif

   assign evt_valid = (count_r != {(PW+1){1'b0}});
   assign evt_id    = mem_r[rd_ptr_r];
   assign pend      = pend_r;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Randomised and directed bench for key_event_arbiter against a queue-based reference model.
module tb_key_event_arbiter;

   localparam int N     = 2;
   localparam int IDW   = 1;
   localparam int DEPTH = 4;
   localparam int PW    = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   key_pulse = '0;
   logic           evt_ready = 1'b0;
   logic           ovf_clr = 1'b0;
   logic           evt_valid;
   logic [IDW-1:0] evt_id;
   logic [N-1:0]   pend;
   logic           ovf;
   logic [7:0]     drop_cnt;

   key_event_arbiter #(.N(N), .IDW(IDW), .DEPTH(DEPTH), .PW(PW)) dut (
      .clk(clk), .rst(rst), .key_pulse(key_pulse), .evt_valid(evt_valid),
      .evt_id(evt_id), .evt_ready(evt_ready), .pend(pend), .ovf(ovf),
      .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // reference model state
   int       m_q[$];
   bit [N-1:0] m_pend;
   int       m_rr;
   bit       m_ovf;
   int       m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_drop();
`ifdef KEY_ARB_DROP_CNT_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   function automatic int exp_drop_lit(input int v);
`ifdef KEY_ARB_DROP_CNT_EN
      return v;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pend = '0;
      m_rr   = N - 1;
      m_ovf  = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic model_step(input bit [N-1:0] p, input bit r, input bit c);
      bit pop;
      int g;
      int nd;
      bit [N-1:0] gm;
      pop = (m_q.size() != 0) && r;
      g = -1;
      gm = '0;
      nd = 0;
      if ((m_q.size() < DEPTH || pop) && m_pend != 0) begin
         for (int k = 1; k <= N; k++) begin
            if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
         end
      end
      if (g >= 0) gm[g] = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (p[i] && m_pend[i] && !gm[i]) nd++;
      end
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin
         m_q.push_back(g);
         m_rr = g;
      end
      m_pend = (m_pend & ~gm) | p;
      if (nd > 0) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      m_cnt = (m_cnt + nd > 255) ? 255 : m_cnt + nd;
   endtask

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
         if (m_q.size() != 0) check("evt_id", 32'(evt_id), 32'(m_q[0]));
         check("pend", 32'(pend), 32'(m_pend));
         check("ovf", 32'(ovf), 32'(m_ovf));
         check("drop_cnt", 32'(drop_cnt), 32'(exp_drop()));
      end
   end

   task automatic cycle(input logic [N-1:0] p, input logic r, input logic c);
      key_pulse = p;
      evt_ready = r;
      ovf_clr   = c;
      @(posedge clk);
      model_step(p, r, c);
      @(negedge clk);
   endtask

   task automatic do_reset();
      chk_en    = 1'b0;
      key_pulse = '0;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_pend", 32'(pend), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_id", 32'(evt_id), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      chk_en = 1'b1;
   endtask

   initial begin
      int seq[5];
      int pct;
      seq = '{0, 1, 0, 1, 0};
      model_reset();
      repeat (2) @(negedge clk);
      check("init_valid", 32'(evt_valid), 32'd0);
      check("init_pend", 32'(pend), 32'd0);
      check("init_id", 32'(evt_id), 32'd0);
      check("init_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b1;
      chk_en = 1'b1;

      // single key, two-cycle latency
      cycle(2'b10, 1'b1, 1'b0);
      check("t1_pend", 32'(pend), 32'h2);
      check("t1_valid_early", 32'(evt_valid), 32'd0);
      cycle(2'b00, 1'b1, 1'b0);
      check("t1_valid", 32'(evt_valid), 32'd1);
      check("t1_id", 32'(evt_id), 32'd1);
      cycle(2'b00, 1'b1, 1'b0);
      check("t1_valid_late", 32'(evt_valid), 32'd0);

      // simultaneous presses serialised
      cycle(2'b11, 1'b1, 1'b0);
      cycle(2'b00, 1'b1, 1'b0);
      check("t2_id0", 32'(evt_id), 32'd0);
      cycle(2'b00, 1'b1, 1'b0);
      check("t2_id1", 32'(evt_id), 32'd1);
      cycle(2'b00, 1'b1, 1'b0);
      check("t2_ovf", 32'(ovf), 32'd0);

      // round-robin fairness against a re-pended key
      cycle(2'b11, 1'b1, 1'b0);
      cycle(2'b00, 1'b1, 1'b0);
      check("t3_id_a", 32'(evt_id), 32'd0);
      cycle(2'b01, 1'b1, 1'b0);
      check("t3_id_b", 32'(evt_id), 32'd1);
      cycle(2'b00, 1'b1, 1'b0);
      check("t3_id_c", 32'(evt_id), 32'd0);
      cycle(2'b00, 1'b1, 1'b0);

      // fill the FIFO with the consumer stalled
      do_reset();
      cycle(2'b11, 1'b0, 1'b0);
      cycle(2'b00, 1'b0, 1'b0);
      cycle(2'b00, 1'b0, 1'b0);
      cycle(2'b11, 1'b0, 1'b0);
      cycle(2'b00, 1'b0, 1'b0);
      cycle(2'b00, 1'b0, 1'b0);
      check("t4_full_pend", 32'(pend), 32'd0);
      check("t4_full_id", 32'(evt_id), 32'd0);
      cycle(2'b01, 1'b0, 1'b0);
      cycle(2'b00, 1'b0, 1'b0);
      check("t4_pend_hold", 32'(pend), 32'h1);
      check("t4_no_ovf", 32'(ovf), 32'd0);

      // drops while full, sticky flag, saturation
      cycle(2'b01, 1'b0, 1'b0);
      check("t5_ovf", 32'(ovf), 32'd1);
      check("t5_drop1", 32'(drop_cnt), 32'(exp_drop_lit(1)));
      cycle(2'b00, 1'b0, 1'b1);
      check("t5_ovf_clr", 32'(ovf), 32'd0);
      check("t5_drop_kept", 32'(drop_cnt), 32'(exp_drop_lit(1)));
      cycle(2'b01, 1'b0, 1'b1);
      check("t5_set_wins", 32'(ovf), 32'd1);
      repeat (300) cycle(2'b01, 1'b0, 1'b0);
      check("t5_sat", 32'(drop_cnt), 32'(exp_drop_lit(255)));
      cycle(2'b00, 1'b0, 1'b1);

      // drain: four queued plus the still-pending key 0
      for (int i = 0; i < 5; i++) begin
         check("t4_drain_valid", 32'(evt_valid), 32'd1);
         check("t4_drain_id", 32'(evt_id), 32'(seq[i]));
         cycle(2'b00, 1'b1, 1'b0);
      end
      check("t4_empty", 32'(evt_valid), 32'd0);

      // reset mid-operation
      cycle(2'b11, 1'b0, 1'b0);
      cycle(2'b00, 1'b0, 1'b0);
      cycle(2'b00, 1'b0, 1'b0);
      cycle(2'b01, 1'b0, 1'b0);
      cycle(2'b00, 1'b0, 1'b0);
      cycle(2'b11, 1'b0, 1'b0);
      check("t6_pre_pend", 32'(pend), 32'h3);
      do_reset();
      cycle(2'b01, 1'b1, 1'b0);
      cycle(2'b00, 1'b1, 1'b0);
      check("t6_valid", 32'(evt_valid), 32'd1);
      check("t6_id", 32'(evt_id), 32'd0);

      // randomised traffic with varying consumer back-pressure
      for (int e = 0; e < 6; e++) begin
         pct = (e % 3 == 0) ? 10 : ((e % 3 == 1) ? 50 : 90);
         for (int c = 0; c < 500; c++) begin
            cycle(N'($urandom_range(0, (1 << N) - 1)),
                  1'($urandom_range(0, 99) < pct),
                  1'($urandom_range(0, 15) == 0));
         end
         if (e == 2) do_reset();
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
